// File: rtl/fpnew_pkg.sv
// Shared FPU types: operation fields, status flags, issue tags and issue-state enum.
package fpnew_pkg;

  localparam int unsigned NUM_TAGS_DEFAULT = 4;
  localparam int unsigned TAG_IDX_W        = $clog2(NUM_TAGS_DEFAULT);
  localparam int unsigned RD_W             = 5;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Epoch bit distinguishes operations issued before and after a flush.
  typedef struct packed {
    logic                 epoch;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic {
    ISSUE_RUN   = 1'b0,
    ISSUE_DRAIN = 1'b1
  } issue_state_e;

endpackage

// File: rtl/fifo_v2.sv
// Synchronous FIFO with flush; optional fall-through when empty.
module fifo_v2 #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stored_empty;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign stored_empty = (cnt_q == '0);
  assign full_o       = (cnt_q == CNT_W'(DEPTH));
  assign bypass       = FALL_THROUGH && stored_empty && push_i && pop_i;
  assign do_push      = push_i & ~full_o & ~bypass;
  assign do_pop       = pop_i & ~stored_empty;

  always_comb begin
    data_o  = mem_q[rd_ptr_q];
    empty_o = stored_empty;
    if (FALL_THROUGH && stored_empty && push_i) begin
      data_o  = data_i;
      empty_o = 1'b0;
    end
  end

  // Pointer wrap is explicit so non-power-of-two depths also work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues core FP requests to the FPU under a tag budget and reorders nothing:
// results are written back in arrival order, with epoch-based flush.
module fpu_issue_ctrl
  import fpnew_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NUM_TAGS = NUM_TAGS_DEFAULT,
  parameter type         TagType  = tag_t
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // core request
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0][WIDTH-1:0] req_operands_i,
  input  operation_e            req_op_i,
  input  logic                  req_op_mod_i,
  input  roundmode_e            req_rnd_mode_i,
  input  fp_format_e            req_src_fmt_i,
  input  fp_format_e            req_dst_fmt_i,
  input  int_format_e           req_int_fmt_i,
  input  logic                  req_vectorial_op_i,
  input  logic [RD_W-1:0]       req_rd_i,
  // FPU issue
  output logic                  fpu_in_valid_o,
  input  logic                  fpu_in_ready_i,
  output logic [2:0][WIDTH-1:0] fpu_operands_o,
  output operation_e            fpu_op_o,
  output logic                  fpu_op_mod_o,
  output roundmode_e            fpu_rnd_mode_o,
  output fp_format_e            fpu_src_fmt_o,
  output fp_format_e            fpu_dst_fmt_o,
  output int_format_e           fpu_int_fmt_o,
  output logic                  fpu_vectorial_op_o,
  output TagType                fpu_tag_o,
  // FPU result
  input  logic                  fpu_out_valid_i,
  input  logic [WIDTH-1:0]      fpu_result_i,
  input  status_t               fpu_status_i,
  input  TagType                fpu_tag_i,
  output logic                  fpu_out_ready_o,
  input  logic                  fpu_busy_i,
  output logic                  fpu_flush_o,
  // writeback
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [RD_W-1:0]       wb_rd_o,
  output logic [WIDTH-1:0]      wb_result_o,
  output status_t               wb_status_o,
  // control / status
  input  logic                  flush_i,
  output status_t               fflags_o,
  input  logic                  fflags_clr_i,
  output logic                  err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_TAGS);

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    status_t          status;
    logic [RD_W-1:0]  rd;
    idx_t             idx;
  } rsp_t;

  localparam int unsigned RSP_W = $bits(rsp_t);

  issue_state_e                  state_q, state_d;
  logic                          epoch_q, epoch_d;
  logic [NUM_TAGS-1:0]           alloc_q, alloc_d;
  logic [NUM_TAGS-1:0][RD_W-1:0] rd_q, rd_d;
  status_t                       fflags_q, fflags_d;
  logic                          err_q, err_d;

  logic       run;
  logic       any_tag_free;
  idx_t       free_idx;
  logic       issue;
  logic [IDX_W:0] res_tag;
  idx_t       res_idx;
  logic       res_cur_epoch;
  logic       res_push;
  logic       res_bad;
  rsp_t       push_data;
  rsp_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       wb_pop;

  assign run          = (state_q == ISSUE_RUN);
  assign any_tag_free = ~&alloc_q;

  // Lowest free index wins.
  always_comb begin
    free_idx = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign req_ready_o    = run & fpu_in_ready_i & any_tag_free & ~flush_i;
  assign fpu_in_valid_o = run & req_valid_i & any_tag_free & ~flush_i;
  assign issue          = fpu_in_valid_o & fpu_in_ready_i;

  assign fpu_operands_o     = req_operands_i;
  assign fpu_op_o           = req_op_i;
  assign fpu_op_mod_o       = req_op_mod_i;
  assign fpu_rnd_mode_o     = req_rnd_mode_i;
  assign fpu_src_fmt_o      = req_src_fmt_i;
  assign fpu_dst_fmt_o      = req_dst_fmt_i;
  assign fpu_int_fmt_o      = req_int_fmt_i;
  assign fpu_vectorial_op_o = req_vectorial_op_i;
  assign fpu_tag_o          = TagType'({epoch_q, free_idx});
  assign fpu_flush_o        = flush_i;
  assign fpu_out_ready_o    = 1'b1;

  // Stale-epoch results are dropped silently; current-epoch results for
  // an unallocated index are protocol errors.
  assign res_tag       = fpu_tag_i;
  assign res_idx       = res_tag[IDX_W-1:0];
  assign res_cur_epoch = (res_tag[IDX_W] == epoch_q);
  assign res_push      = fpu_out_valid_i & res_cur_epoch & alloc_q[res_idx] & ~flush_i & ~fifo_full;
  assign res_bad       = fpu_out_valid_i & res_cur_epoch & ~alloc_q[res_idx];

  assign push_data = '{result: fpu_result_i, status: fpu_status_i, rd: rd_q[res_idx], idx: res_idx};

  fifo_v2 #(
    .DATA_WIDTH  (RSP_W),
    .DEPTH       (NUM_TAGS),
    .FALL_THROUGH(1'b0)
  ) i_rsp_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .push_i (res_push),
    .data_i (push_data),
    .pop_i  (wb_pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign wb_valid_o  = ~fifo_empty;
  assign wb_rd_o     = head.rd;
  assign wb_result_o = head.result;
  assign wb_status_o = head.status;
  assign wb_pop      = wb_valid_o & wb_ready_i;

  assign fflags_o = fflags_q;
  assign err_o    = err_q;

  always_comb begin
    state_d  = state_q;
    epoch_d  = epoch_q;
    alloc_d  = alloc_q;
    rd_d     = rd_q;
    fflags_d = fflags_q;
    err_d    = err_q;

    case (state_q)
      ISSUE_RUN:   state_d = ISSUE_RUN;
      ISSUE_DRAIN: if (!fpu_busy_i) state_d = ISSUE_RUN;
    endcase

    // A tag is released only when its result leaves the FIFO.
    if (wb_pop) begin
      alloc_d[head.idx] = 1'b0;
    end
    if (issue) begin
      alloc_d[free_idx] = 1'b1;
      rd_d[free_idx]    = req_rd_i;
    end
    if (res_bad) begin
      err_d = 1'b1;
    end

    if (fflags_clr_i) begin
      fflags_d = wb_pop ? wb_status_o : '0;
    end else if (wb_pop) begin
      fflags_d = fflags_q | wb_status_o;
    end

    if (flush_i) begin
      state_d = ISSUE_DRAIN;
      epoch_d = ~epoch_q;
      alloc_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ISSUE_RUN;
      epoch_q  <= 1'b0;
      alloc_q  <= '0;
      rd_q     <= '0;
      fflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      epoch_q  <= epoch_d;
      alloc_q  <= alloc_d;
      rd_q     <= rd_d;
      fflags_q <= fflags_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scenario bench for fpu_issue_ctrl with an in-order writeback scoreboard.
module tb_fpu_issue_ctrl;
  import fpnew_pkg::*;

  localparam int unsigned WIDTH = 64;
  localparam status_t ST_0  = 5'b00000;
  localparam status_t ST_NX = 5'b00001;
  localparam status_t ST_OF = 5'b00100;
  localparam status_t ST_NV = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  req_valid, req_ready;
  logic [2:0][WIDTH-1:0] req_operands;
  operation_e            req_op;
  logic                  req_op_mod;
  roundmode_e            req_rnd;
  fp_format_e            req_src_fmt, req_dst_fmt;
  int_format_e           req_int_fmt;
  logic                  req_vec;
  logic [4:0]            req_rd;
  logic                  fpu_in_valid, fpu_in_ready;
  logic [2:0][WIDTH-1:0] fpu_operands;
  operation_e            fpu_op;
  logic                  fpu_op_mod;
  roundmode_e            fpu_rnd;
  fp_format_e            fpu_src_fmt, fpu_dst_fmt;
  int_format_e           fpu_int_fmt;
  logic                  fpu_vec;
  tag_t                  fpu_tag_out;
  logic                  fpu_out_valid;
  logic [WIDTH-1:0]      fpu_result;
  status_t               fpu_status;
  tag_t                  fpu_tag_in;
  logic                  fpu_out_ready, fpu_busy, fpu_flush;
  logic                  wb_valid, wb_ready;
  logic [4:0]            wb_rd;
  logic [WIDTH-1:0]      wb_result;
  status_t               wb_status;
  logic                  flush;
  status_t               fflags;
  logic                  fflags_clr;
  logic                  err;

  fpu_issue_ctrl #(.WIDTH(WIDTH), .NUM_TAGS(4), .TagType(tag_t)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_op_i(req_op), .req_op_mod_i(req_op_mod), .req_rnd_mode_i(req_rnd),
    .req_src_fmt_i(req_src_fmt), .req_dst_fmt_i(req_dst_fmt), .req_int_fmt_i(req_int_fmt),
    .req_vectorial_op_i(req_vec), .req_rd_i(req_rd),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready), .fpu_operands_o(fpu_operands),
    .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod), .fpu_rnd_mode_o(fpu_rnd),
    .fpu_src_fmt_o(fpu_src_fmt), .fpu_dst_fmt_o(fpu_dst_fmt), .fpu_int_fmt_o(fpu_int_fmt),
    .fpu_vectorial_op_o(fpu_vec), .fpu_tag_o(fpu_tag_out),
    .fpu_out_valid_i(fpu_out_valid), .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
    .fpu_tag_i(fpu_tag_in), .fpu_out_ready_o(fpu_out_ready), .fpu_busy_i(fpu_busy),
    .fpu_flush_o(fpu_flush),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
    .wb_result_o(wb_result), .wb_status_o(wb_status),
    .flush_i(flush), .fflags_o(fflags), .fflags_clr_i(fflags_clr), .err_o(err)
  );

  typedef struct {
    logic [4:0]       rd;
    logic [WIDTH-1:0] res;
    status_t          st;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic tag_t mk_tag(input logic e, input int i);
    tag_t t;
    t.epoch = e;
    t.idx   = 2'(i);
    return t;
  endfunction

  // Every writeback must match the oldest expected entry.
  task automatic monitor_wb();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && wb_valid && wb_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL wb_unexpected: got rd=%0d result=%h, required no writeback", wb_rd, wb_result);
        end else begin
          e = sb_q.pop_front();
          if (wb_rd !== e.rd || wb_result !== e.res || wb_status !== e.st) begin
            n_bad++;
            $display("FAIL wb_data: got rd=%0d res=%h st=%b, required rd=%0d res=%h st=%b",
                     wb_rd, wb_result, wb_status, e.rd, e.res, e.st);
          end
        end
      end
    end
  endtask

  task automatic issue_op(input logic [4:0] rd, output tag_t tag, output bit ok);
    int t = 0;
    req_valid    = 1'b1;
    req_rd       = rd;
    req_operands = {64'(rd) * 3, 64'(rd) * 2, 64'(rd)};
    @(negedge clk);
    while (!(fpu_in_valid && fpu_in_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok  = (t < 20);
    tag = fpu_tag_out;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_result(input tag_t tag, input logic [4:0] rd, input status_t st, input bit expect_wb);
    exp_t e;
    if (expect_wb) begin
      e.rd  = rd;
      e.res = 64'hC0DE_0000_0000_0000 | 64'(rd);
      e.st  = st;
      sb_q.push_back(e);
    end
    fpu_out_valid = 1'b1;
    fpu_tag_in    = tag;
    fpu_result    = 64'hC0DE_0000_0000_0000 | 64'(rd);
    fpu_status    = st;
    @(posedge clk); #1;
    fpu_out_valid = 1'b0;
  endtask

  task automatic wait_drained(output bit ok);
    int t = 0;
    while ((sb_q.size() != 0 || wb_valid) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (t < 50);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0 || fpu_in_valid !== 1'b0 || err !== 1'b0 || fflags !== ST_0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_outputs: got wb_valid=%b in_valid=%b err=%b fflags=%b req_ready=%b, required 0 0 0 00000 1",
               wb_valid, fpu_in_valid, err, fflags, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1 || fpu_flush !== 1'b0 || fpu_out_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset: got wb_valid=%b err=%b req_ready=%b flush_o=%b out_ready=%b, required 0 0 1 0 1",
               wb_valid, err, req_ready, fpu_flush, fpu_out_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    tag_t tg;
    bit   ok;
    logic [2:0][WIDTH-1:0] ops;
    exp_t e;
    wb_ready     = 1'b1;
    ops          = {64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    req_operands = ops;
    req_op       = ADD;
    req_rd       = 5'd5;
    req_valid    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fpu_in_valid !== 1'b1 || fpu_tag_out !== mk_tag(1'b0, 0)) begin
      n_bad++;
      $display("FAIL single_issue: got valid=%b tag=%b, required 1 000", fpu_in_valid, fpu_tag_out);
    end
    n_cmp++;
    if (fpu_operands !== ops || fpu_op !== ADD || fpu_rnd !== req_rnd || fpu_src_fmt !== FP64) begin
      n_bad++;
      $display("FAIL single_passthru: got op=%0d ops=%h, required op=%0d ops=%h", fpu_op, fpu_operands, ADD, ops);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e.rd = 5'd5; e.res = 64'h4010_0000_0000_0000; e.st = ST_0;
    sb_q.push_back(e);
    fpu_out_valid = 1'b1; fpu_tag_in = mk_tag(1'b0, 0); fpu_result = e.res; fpu_status = ST_0;
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_wb_early: got wb_valid=%b in result cycle, required 0", wb_valid);
    end
    @(posedge clk); #1;
    fpu_out_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5) begin
      n_bad++;
      $display("FAIL single_wb_next: got wb_valid=%b rd=%0d, required 1 5", wb_valid, wb_rd);
    end
    @(posedge clk); #1;
    issue_op(5'd6, tg, ok);
    n_cmp++;
    if (!ok || tg !== mk_tag(1'b0, 0)) begin
      n_bad++;
      $display("FAIL single_tag_freed: got ok=%b tag=%b, required 1 000", ok, tg);
    end
    send_result(tg, 5'd6, ST_0, 1'b1);
    wait_drained(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_drain: got pending=%0d, required 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wb_ready  = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_rd = 5'(10 + i);
      @(negedge clk);
      n_cmp++;
      if (fpu_in_valid !== 1'b1 || fpu_tag_out !== mk_tag(1'b0, i)) begin
        n_bad++;
        $display("FAIL b2b_issue%0d: got valid=%b tag=%b, required 1 0%0d", i, fpu_in_valid, fpu_tag_out, i);
      end
      @(posedge clk); #1;
    end
    req_rd = 5'd14;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || fpu_in_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_full: got req_ready=%b in_valid=%b, required 0 0", req_ready, fpu_in_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_result(mk_tag(1'b0, i), 5'(10 + i), ST_0, 1'b1);
    wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || wb_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_pop_cycle: got req_ready=%b wb_valid=%b, required 0 1", req_ready, wb_valid);
    end
    @(posedge clk); #1;
    wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fpu_in_valid !== 1'b1 || fpu_tag_out !== mk_tag(1'b0, 0)) begin
      n_bad++;
      $display("FAIL b2b_resume: got valid=%b tag=%b, required 1 000", fpu_in_valid, fpu_tag_out);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    send_result(mk_tag(1'b0, 0), 5'd14, ST_0, 1'b1);
    wb_ready = 1'b1;
    wait_drained(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_drain: got pending=%0d, required 0", sb_q.size()); end
  endtask

  task automatic test_out_of_order();
    tag_t tg;
    bit   ok;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_op(5'(20 + i), tg, ok);
      n_cmp++;
      if (!ok || tg !== mk_tag(1'b0, i)) begin
        n_bad++;
        $display("FAIL ooo_issue%0d: got ok=%b tag=%b, required 1 0%0d", i, ok, tg, i);
      end
    end
    // Result for tag 2 arrives in the same cycle that tag 3 issues.
    req_valid = 1'b1;
    req_rd    = 5'd23;
    sb_q.push_back('{5'd22, 64'hC0DE_0000_0000_0016, ST_0});
    fpu_out_valid = 1'b1; fpu_tag_in = mk_tag(1'b0, 2);
    fpu_result = 64'hC0DE_0000_0000_0016; fpu_status = ST_0;
    @(negedge clk);
    n_cmp++;
    if (fpu_in_valid !== 1'b1 || fpu_tag_out !== mk_tag(1'b0, 3)) begin
      n_bad++;
      $display("FAIL ooo_same_cycle: got valid=%b tag=%b, required 1 011", fpu_in_valid, fpu_tag_out);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; fpu_out_valid = 1'b0;
    send_result(mk_tag(1'b0, 0), 5'd20, ST_0, 1'b1);
    send_result(mk_tag(1'b0, 1), 5'd21, ST_0, 1'b1);
    send_result(mk_tag(1'b0, 3), 5'd23, ST_0, 1'b1);
    wait_drained(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ooo_drain: got pending=%0d, required 0", sb_q.size()); end
  endtask

  task automatic test_fflags();
    tag_t tg;
    bit   ok;
    wb_ready   = 1'b0;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    issue_op(5'd3, tg, ok);
    issue_op(5'd4, tg, ok);
    send_result(mk_tag(1'b0, 0), 5'd3, ST_NX, 1'b1);
    send_result(mk_tag(1'b0, 1), 5'd4, ST_OF, 1'b1);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fflags !== ST_NX) begin n_bad++; $display("FAIL fflags_nx: got %b, required %b", fflags, ST_NX); end
    @(posedge clk); #1;
    wb_ready = 1'b1; fflags_clr = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0; fflags_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fflags !== ST_OF) begin n_bad++; $display("FAIL fflags_clr_pop: got %b, required %b", fflags, ST_OF); end
    @(posedge clk); #1;
    issue_op(5'd2, tg, ok);
    send_result(tg, 5'd2, ST_NV, 1'b1);
    wb_ready = 1'b1;
    wait_drained(ok);
    n_cmp++;
    if (!ok || fflags !== 5'b10100) begin
      n_bad++;
      $display("FAIL fflags_accum: got ok=%b fflags=%b, required 1 10100", ok, fflags);
    end
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    n_cmp++;
    if (fflags !== ST_0) begin n_bad++; $display("FAIL fflags_clear: got %b, required 00000", fflags); end
  endtask

  task automatic test_flush();
    tag_t tg;
    bit   ok;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue_op(5'(1 + i), tg, ok);
    fpu_busy = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fpu_flush !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_comb: got flush_o=%b req_ready=%b, required 1 0", fpu_flush, req_ready);
    end
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b1;
    req_rd    = 5'd7;
    for (int i = 0; i < 3; i++) send_result(mk_tag(1'b0, i), 5'(1 + i), ST_0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0 || err !== 1'b0 || fpu_in_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drain: got wb_valid=%b err=%b in_valid=%b req_ready=%b, required 0 0 0 0",
               wb_valid, err, fpu_in_valid, req_ready);
    end
    @(posedge clk); #1;
    fpu_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fpu_in_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_busy_sample: got in_valid=%b, required 0", fpu_in_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (fpu_in_valid !== 1'b1 || fpu_tag_out !== mk_tag(1'b1, 0)) begin
      n_bad++;
      $display("FAIL flush_next_tag: got valid=%b tag=%b, required 1 100", fpu_in_valid, fpu_tag_out);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    send_result(mk_tag(1'b1, 0), 5'd7, ST_0, 1'b1);
    wait_drained(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL flush_wb: got pending=%0d, required 0", sb_q.size()); end
  endtask

  task automatic test_flush_in_drain();
    tag_t tg;
    bit   ok;
    fpu_busy = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    fpu_busy  = 1'b0;
    req_valid = 1'b1;
    req_rd    = 5'd8;
    @(negedge clk);
    n_cmp++;
    if (fpu_in_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_reflush_hold: got in_valid=%b, required 0", fpu_in_valid);
    end
    @(posedge clk); #1;
    issue_op(5'd8, tg, ok);
    n_cmp++;
    if (!ok || tg !== mk_tag(1'b1, 0)) begin
      n_bad++;
      $display("FAIL drain_reflush_epoch: got ok=%b tag=%b, required 1 100", ok, tg);
    end
    send_result(tg, 5'd8, ST_0, 1'b1);
    wait_drained(ok);
  endtask

  task automatic test_reset_mid_op();
    tag_t tg;
    bit   ok;
    wb_ready = 1'b0;
    issue_op(5'd9, tg, ok);
    send_result(tg, 5'd9, ST_0, 1'b0);
    wb_ready = 1'b1;
    rst      = 1'b1;
    #1;
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abandon: got wb_valid=%b, required 0", wb_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue_op(5'd11, tg, ok);
    n_cmp++;
    if (!ok || tg !== mk_tag(1'b0, 0)) begin
      n_bad++;
      $display("FAIL reset_epoch: got ok=%b tag=%b, required 1 000", ok, tg);
    end
    send_result(tg, 5'd11, ST_0, 1'b1);
    wait_drained(ok);
  endtask

  task automatic test_bad_tag();
    tag_t tg;
    bit   ok;
    send_result(mk_tag(1'b0, 3), 5'd31, ST_0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_tag_err: got err=%b wb_valid=%b, required 1 0", err, wb_valid);
    end
    @(posedge clk); #1;
    issue_op(5'd12, tg, ok);
    send_result(tg, 5'd12, ST_0, 1'b1);
    wait_drained(ok);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL bad_tag_sticky: got err=%b, required 1", err); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL bad_tag_reset: got err=%b, required 0", err); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_operands = '0; req_op = ADD; req_op_mod = 1'b0;
    req_rnd = RNE; req_src_fmt = FP64; req_dst_fmt = FP64; req_int_fmt = INT32; req_vec = 1'b0;
    req_rd = '0; fpu_in_ready = 1'b1; fpu_out_valid = 1'b0; fpu_result = '0; fpu_status = ST_0;
    fpu_tag_in = '0; fpu_busy = 1'b0; wb_ready = 1'b1; flush = 1'b0; fflags_clr = 1'b0;
    fork
      monitor_wb();
    join_none
    test_reset();
    test_single_add();
    test_back_to_back();
    test_out_of_order();
    test_fflags();
    test_flush();
    test_flush_in_drain();
    test_reset_mid_op();
    test_bad_tag();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning FP operand and result width.
REQ-002 SHALL have parameter NUM_TAGS, default 4 (power of two), meaning the maximum number of operations outstanding in the FPU.
REQ-003 SHALL have parameter type TagType (= {1-bit epoch, $clog2(NUM_TAGS)-bit index}), declared in the package.
REQ-004 clk_i  in  1  sole clock; one clock domain, all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 req_valid_i/req_ready_o  in/out  1  core request handshake.
REQ-007 req_operands_i  in  3xWIDTH  operands; req_op_i, req_op_mod_i, req_rnd_mode_i, req_src_fmt_i, req_dst_fmt_i, req_int_fmt_i, req_vectorial_op_i  in  fpnew_pkg types  operation fields.
REQ-008 req_rd_i  in  5  destination register index.
REQ-009 fpu_in_valid_o/fpu_in_ready_i  out/in  1  FPU issue handshake; fpu_operands_o and op fields out mirror the req_* fields; fpu_tag_o  out  TagType.
REQ-010 fpu_out_valid_i  in  1  result pulse; fpu_result_i  in  WIDTH; fpu_status_i  in  status_t; fpu_tag_i  in  TagType; fpu_out_ready_o  out  1; fpu_busy_i  in  1; fpu_flush_o  out  1.
REQ-011 wb_valid_o/wb_ready_i  out/in  1  writeback handshake; wb_rd_o 5, wb_result_o WIDTH, wb_status_o status_t.
REQ-012 flush_i  in  1  kill all outstanding operations; fflags_o  out  status_t  sticky flags; fflags_clr_i  in  1; err_o  out  1  sticky protocol error.

Function
REQ-013 State machine SHALL have two states, RUN and DRAIN; reset state is RUN.
REQ-014 In RUN, req_ready_o SHALL be fpu_in_ready_i & any_tag_free & !flush_i, combinationally.
REQ-015 fpu_in_valid_o SHALL be req_valid_i & any_tag_free & !flush_i & (state==RUN), with the req_* fields passed through with zero latency.
REQ-016 On issue (fpu_in_valid_o & fpu_in_ready_i), the lowest free index SHALL be allocated, rd stored in the tag table, and fpu_tag_o = {epoch, index}.
REQ-017 fpu_out_ready_o SHALL be tied 1; every fpu_out_valid_i pulse SHALL be consumed that cycle.
REQ-018 A result whose epoch equals the current epoch and whose index is allocated SHALL be pushed into a NUM_TAGS-deep response FIFO (result, status, stored rd, index).
REQ-019 A result with a stale epoch SHALL be discarded silently.
REQ-020 A current-epoch result with an unallocated index SHALL be discarded and SHALL set err_o.
REQ-021 wb_* SHALL present the FIFO head; the earliest wb_valid_o is the cycle after fpu_out_valid_i.
REQ-022 A tag SHALL be freed on wb pop (wb_valid_o & wb_ready_i); the freed index is reusable from the next cycle only.
REQ-023 Simultaneous FIFO push and pop SHALL be supported; overflow is impossible by construction (tags freed only at pop).
REQ-024 On wb pop, fflags_o SHALL OR in wb_status_o; fflags_clr_i clears fflags_o, and a pop in the same cycle as a clear SHALL leave only that pop's flags.
REQ-025 flush_i SHALL drive fpu_flush_o combinationally, and at the next edge SHALL toggle epoch, free all tags, empty the FIFO, and enter DRAIN.
REQ-026 In DRAIN, no issue SHALL occur; the block SHALL return to RUN in the cycle after fpu_busy_i is sampled low.
REQ-027 A flush_i during DRAIN SHALL re-toggle epoch and remain in DRAIN.
REQ-028 When issue and result arrival occur in the same cycle, both SHALL take effect.

Reset
REQ-029 Reset SHALL yield: state RUN, epoch 0, all tags free, FIFO empty, fflags_o 0, err_o 0, wb_valid_o 0, fpu_in_valid_o 0.
REQ-030 Reset mid-operation SHALL abandon all outstanding tags without writeback.

Structure
REQ-031 TagType, the issue-state enum, and NUM_TAGS default SHALL live in fpnew_pkg.
REQ-032 The response FIFO SHALL be the sub-module fifo_v2 (DEPTH=NUM_TAGS, FALL_THROUGH=0).

Verification
REQ-033 Single ADD issue, result pulse with tag {0,0} at cycle 5 -> wb_valid_o at cycle 6, wb_rd_o = issued rd, tag 0 freed after pop.
REQ-034 Four back-to-back issues with wb_ready_i=0 -> req_ready_o=0 on the 5th request; one pop -> index freed, issue resumes the next cycle with that index.
REQ-035 Results returned out of order (tags 2,0,1) -> wb order 2,0,1 with matching rd values.
REQ-036 flush_i with 3 outstanding, then stale results {0,x} -> no wb_valid_o, err_o=0, DRAIN held until fpu_busy_i=0, next tag {1,0}.
REQ-037 Result with tag {0,3} never issued -> discarded, err_o=1 and stays 1 until reset.
REQ-038 Pops with status NX then OF, with fflags_clr_i asserted on the second pop -> fflags_o = OF only.
